// File: rtl/id_ex_operand_stage.sv
// Operand stage: resolves EX/MEM forwarding and load-use hazards, registers operands into ID/EX.
// Latency: 1 cycle ID -> EX outputs; a load-use hazard adds exactly one bubble cycle.
// Backpressure: stall holds all EX state; load_use_stall asks the front end to hold PC and IF/ID.
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_p0_addr,
  input  logic [ADDR_W-1:0] id_p1_addr,
  input  logic              id_re0,
  input  logic              id_re1,
  input  logic [ADDR_W-1:0] id_dst_addr,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic [DATA_W-1:0] rf_p0,
  input  logic [DATA_W-1:0] rf_p1,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [ADDR_W-1:0] mem_dst_addr,
  input  logic              mem_we,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op0,
  output logic [DATA_W-1:0] ex_op1,
  output logic [ADDR_W-1:0] ex_dst_addr,
  output logic              ex_we,
  output logic              ex_is_load,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count
);

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_op0_q, ex_op0_d;
  logic [DATA_W-1:0] ex_op1_q, ex_op1_d;
  logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              hit_ex0, hit_ex1, hit_mem0, hit_mem1;
  logic              lus;
  logic [DATA_W-1:0] sel_op0, sel_op1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Hazard detection: R0 never matches; WB needs no path since the rf is write-before-read.
  always_comb begin
    hit_ex0  = id_re0 & ex_valid_q & ex_we_q & (ex_dst_q == id_p0_addr) & (id_p0_addr != '0);
    hit_ex1  = id_re1 & ex_valid_q & ex_we_q & (ex_dst_q == id_p1_addr) & (id_p1_addr != '0);
    hit_mem0 = id_re0 & mem_we & (mem_dst_addr == id_p0_addr) & (id_p0_addr != '0);
    hit_mem1 = id_re1 & mem_we & (mem_dst_addr == id_p1_addr) & (id_p1_addr != '0);
    // An external hold already freezes the front end, so no separate request then.
    lus      = id_valid & ex_is_load_q & (hit_ex0 | hit_ex1) & ~stall;
  end

  // Operand select: youngest producer wins; a load in EX cannot forward yet.
  always_comb begin
    sel_op0 = rf_p0;
    sel_op1 = rf_p1;
    if (hit_ex0 && !ex_is_load_q) begin
      sel_op0 = ex_result;
    end else if (hit_mem0) begin
      sel_op0 = mem_result;
    end
    if (hit_ex1 && !ex_is_load_q) begin
      sel_op1 = ex_result;
    end else if (hit_mem1) begin
      sel_op1 = mem_result;
    end
  end

  // Next-state for the ID/EX register: flush > stall > load-use bubble > capture.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_op0_d     = ex_op0_q;
    ex_op1_d     = ex_op1_q;
    ex_dst_d     = ex_dst_q;
    ex_we_d      = ex_we_q;
    ex_is_load_d = ex_is_load_q;
    cnt_d        = cnt_q;
    if (flush) begin
      ex_valid_d   = 1'b0;
      ex_we_d      = 1'b0;
      ex_is_load_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (lus) begin
      ex_valid_d   = 1'b0;
      ex_we_d      = 1'b0;
      ex_is_load_d = 1'b0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      ex_valid_d   = id_valid;
      ex_we_d      = id_we & id_valid;
      ex_is_load_d = id_is_load & id_valid;
      ex_dst_d     = id_dst_addr;
      ex_op0_d     = sel_op0;
      ex_op1_d     = sel_op1;
    end
  end

  // ID/EX pipeline register and stall counter; reset clears EX contents immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_op0_q     <= '0;
      ex_op1_q     <= '0;
      ex_dst_q     <= '0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_op0_q     <= ex_op0_d;
      ex_op1_q     <= ex_op1_d;
      ex_dst_q     <= ex_dst_d;
      ex_we_q      <= ex_we_d;
      ex_is_load_q <= ex_is_load_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_op0         = ex_op0_q;
  assign ex_op1         = ex_op1_q;
  assign ex_dst_addr    = ex_dst_q;
  assign ex_we          = ex_we_q;
  assign ex_is_load     = ex_is_load_q;
  assign load_use_stall = lus;
  assign stall_count    = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: driver computes expected EX state from a producer-lookup model,
// monitor pops and compares after every clock edge; a CNT_W=4 copy checks saturation.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_re0, id_re1, id_we, id_is_load;
  logic [3:0]  id_p0_addr, id_p1_addr, id_dst_addr, mem_dst_addr;
  logic [15:0] rf_p0, rf_p1, ex_result, mem_result;
  logic        mem_we, stall, flush;

  logic        ex_valid, ex_we, ex_is_load, lus;
  logic [15:0] ex_op0, ex_op1, stall_count;
  logic [3:0]  ex_dst_addr;

  logic        ex_valid4, ex_we4, ex_is_load4, lus4;
  logic [15:0] ex_op0_4, ex_op1_4;
  logic [3:0]  ex_dst4, stall_count4;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
    .id_re0(id_re0), .id_re1(id_re1), .id_dst_addr(id_dst_addr), .id_we(id_we),
    .id_is_load(id_is_load), .rf_p0(rf_p0), .rf_p1(rf_p1), .ex_result(ex_result),
    .mem_result(mem_result), .mem_dst_addr(mem_dst_addr), .mem_we(mem_we), .stall(stall),
    .flush(flush), .ex_valid(ex_valid), .ex_op0(ex_op0), .ex_op1(ex_op1),
    .ex_dst_addr(ex_dst_addr), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .load_use_stall(lus), .stall_count(stall_count));

  id_ex_operand_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
    .id_re0(id_re0), .id_re1(id_re1), .id_dst_addr(id_dst_addr), .id_we(id_we),
    .id_is_load(id_is_load), .rf_p0(rf_p0), .rf_p1(rf_p1), .ex_result(ex_result),
    .mem_result(mem_result), .mem_dst_addr(mem_dst_addr), .mem_we(mem_we), .stall(stall),
    .flush(flush), .ex_valid(ex_valid4), .ex_op0(ex_op0_4), .ex_op1(ex_op1_4),
    .ex_dst_addr(ex_dst4), .ex_we(ex_we4), .ex_is_load(ex_is_load4),
    .load_use_stall(lus4), .stall_count(stall_count4));

  typedef struct packed {
    logic        lus;
    logic        v;
    logic        we;
    logic        ld;
    logic [3:0]  dst;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Model of what the EX register should hold.
  logic        m_v, m_we, m_ld;
  logic [3:0]  m_dst;
  logic [15:0] m_op0, m_op1;
  int          m_cnt, m_cnt4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural read of register a: the youngest in-flight writer of a supplies the value;
  // if that writer is a load still in EX, the value does not exist yet (hazard).
  function automatic logic [15:0] read_reg(input logic re, input logic [3:0] a,
                                           input logic [15:0] rfv, output logic hz);
    hz = 1'b0;
    if (!re || a == 4'd0) return rfv;
    if (m_v && m_we && m_dst == a) begin
      if (m_ld) begin
        hz = 1'b1;
        return rfv;
      end
      return ex_result;
    end
    if (mem_we && mem_dst_addr == a) return mem_result;
    return rfv;
  endfunction

  task automatic apply();
    logic h0, h1, l;
    logic [15:0] v0, v1;
    exp_t e;
    v0 = read_reg(id_re0, id_p0_addr, rf_p0, h0);
    v1 = read_reg(id_re1, id_p1_addr, rf_p1, h1);
    l  = id_valid && !stall && (h0 || h1);
    if (flush) begin
      m_v = 0; m_we = 0; m_ld = 0;
    end else if (stall) begin
      // nothing moves
    end else if (l) begin
      m_v = 0; m_we = 0; m_ld = 0;
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end else begin
      m_v = id_valid; m_we = id_we & id_valid; m_ld = id_is_load & id_valid;
      m_dst = id_dst_addr; m_op0 = v0; m_op1 = v1;
    end
    e.lus = l; e.v = m_v; e.we = m_we; e.ld = m_ld; e.dst = m_dst;
    e.op0 = m_op0; e.op1 = m_op1; e.cnt = m_cnt[15:0]; e.cnt4 = m_cnt4[3:0];
    sb_q.push_back(e);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_re0 = 0; id_re1 = 0; id_we = 0; id_is_load = 0;
    id_p0_addr = 0; id_p1_addr = 0; id_dst_addr = 0; mem_dst_addr = 0;
    rf_p0 = 0; rf_p1 = 0; ex_result = 0; mem_result = 0;
    mem_we = 0; stall = 0; flush = 0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  // Instruction in ID: valid, reads a0/a1, writes dst.
  task automatic instr(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] dst,
                       input logic ld);
    id_valid = 1; id_re0 = 1; id_re1 = 1; id_p0_addr = a0; id_p1_addr = a1;
    id_dst_addr = dst; id_we = 1; id_is_load = ld;
  endtask

  // Monitor: sample the combinational stall request mid-cycle, EX state after the edge.
  initial begin
    logic s_lus, s_lus4;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      s_lus = lus; s_lus4 = lus4;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("load_use_stall", {31'd0, s_lus}, {31'd0, e.lus});
        check("ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
        check("ex_we", {31'd0, ex_we}, {31'd0, e.we});
        check("ex_is_load", {31'd0, ex_is_load}, {31'd0, e.ld});
        check("stall_count", {16'd0, stall_count}, {16'd0, e.cnt});
        check("stall_count4", {28'd0, stall_count4}, {28'd0, e.cnt4});
        check("ex_valid4", {28'd0, ex_valid4, ex_we4, ex_is_load4, s_lus4},
              {28'd0, e.v, e.we, e.ld, e.lus});
        if (e.v) begin
          check("ex_op0", {16'd0, ex_op0}, {16'd0, e.op0});
          check("ex_op1", {16'd0, ex_op1}, {16'd0, e.op1});
          check("ex_dst_addr", {28'd0, ex_dst_addr}, {28'd0, e.dst});
          check("ex_ops4", {ex_op0_4, ex_op1_4}, {e.op0, e.op1});
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1;
    m_v = 0; m_we = 0; m_ld = 0; m_dst = 0; m_op0 = 0; m_op1 = 0; m_cnt = 0; m_cnt4 = 0;
    @(posedge clk); #1;
    check("reset_state", {ex_valid, ex_we, ex_is_load, ex_dst_addr, stall_count[9:0], ex_op0[7:0], ex_op1[7:0]}, 32'd0);
    @(negedge clk); rst = 0;

    // Plain capture, no hits.
    begin_cycle(); instr(4'd1, 4'd2, 4'd3, 0); rf_p0 = 16'h1234; rf_p1 = 16'h00FF; apply();
    // EX forward of R3, then EX beats MEM.
    begin_cycle(); instr(4'd3, 4'd2, 4'd3, 0); ex_result = 16'hBEEF; apply();
    begin_cycle(); instr(4'd3, 4'd2, 4'd4, 0); ex_result = 16'hBEEF;
    mem_we = 1; mem_dst_addr = 4'd3; mem_result = 16'h1111; apply();
    // R0 guard.
    begin_cycle(); instr(4'd1, 4'd2, 4'd0, 0); rf_p0 = 16'h5555; apply();
    begin_cycle(); instr(4'd0, 4'd0, 4'd6, 0); ex_result = 16'hDEAD;
    mem_we = 1; mem_dst_addr = 4'd0; mem_result = 16'h7777; apply();
    // Load-use: LW R5 then read R5 on p1, then MEM supplies it.
    begin_cycle(); instr(4'd1, 4'd2, 4'd5, 1); apply();
    begin_cycle(); instr(4'd1, 4'd5, 4'd7, 0); rf_p1 = 16'h0BAD; apply();
    begin_cycle(); instr(4'd1, 4'd5, 4'd7, 0); rf_p1 = 16'h0BAD;
    mem_we = 1; mem_dst_addr = 4'd5; mem_result = 16'hCAFE; apply();
    // Both sources hit the same EX load: single stall; then mixed EX/MEM forward.
    begin_cycle(); instr(4'd1, 4'd2, 4'd8, 1); apply();
    begin_cycle(); instr(4'd8, 4'd8, 4'd9, 0); apply();
    begin_cycle(); instr(4'd8, 4'd8, 4'd9, 0); mem_we = 1; mem_dst_addr = 4'd8; mem_result = 16'h4242; apply();
    begin_cycle(); instr(4'd9, 4'd8, 4'd2, 0); ex_result = 16'h9999;
    mem_we = 1; mem_dst_addr = 4'd8; mem_result = 16'h4343; apply();
    // External stall for 3 cycles with fresh ID data, then stall+flush.
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); instr(4'd2, 4'd2, 4'd11, 1); stall = 1; rf_p0 = 16'(i + 16'h0100); apply();
    end
    begin_cycle(); instr(4'd2, 4'd2, 4'd11, 0); stall = 1; flush = 1; apply();
    // 17 load-use stalls to saturate the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      begin_cycle(); instr(4'd1, 4'd2, 4'd5, 1); apply();
      begin_cycle(); instr(4'd5, 4'd3, 4'd6, 0); apply();
    end
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      begin_cycle();
      id_valid = ($urandom_range(0, 9) != 0);
      id_re0 = $urandom_range(0, 1); id_re1 = $urandom_range(0, 1);
      id_p0_addr = 4'($urandom_range(0, 5)); id_p1_addr = 4'($urandom_range(0, 5));
      id_dst_addr = 4'($urandom_range(0, 5)); id_we = ($urandom_range(0, 3) != 0);
      id_is_load = ($urandom_range(0, 2) == 0);
      rf_p0 = 16'($urandom); rf_p1 = 16'($urandom);
      ex_result = 16'($urandom); mem_result = 16'($urandom);
      mem_dst_addr = 4'($urandom_range(0, 5)); mem_we = $urandom_range(0, 1);
      stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
      apply();
    end
    begin_cycle();
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 0);

    // Async reset mid-cycle with a valid instruction in EX.
    @(negedge clk); idle_inputs(); instr(4'd1, 4'd2, 4'd3, 1); rf_p0 = 16'hAAAA;
    @(posedge clk); #2;
    check("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
    rst = 1; #1;
    check("async_reset", {ex_valid, ex_we, ex_is_load, ex_dst_addr, stall_count[9:0], ex_op0[7:0], ex_op1[7:0]}, 32'd0);
    check("async_reset_ops", {ex_op0, ex_op1}, 32'd0);
    check("async_reset_cnt4", {28'd0, stall_count4}, 32'd0);
    @(negedge clk); rst = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Sits directly downstream of the triple-ported register file.
- Takes the decoded ID-stage instruction and the rf read-port data (p0/p1), resolves EX and MEM data hazards by forwarding, and detects load-use hazards.
- Registers the resolved operands into the ID/EX pipeline register that feeds the ALU.
- WB needs no forwarding path: the rf writes on clock high and reads on clock low, so a same-cycle WB write is already visible on p0/p1.

Parameters:
DATA_W, 16, operand/result width
ADDR_W, 4, register address width (16 registers, R0 hardwired zero)
CNT_W, 16, width of the load-use stall counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_p0_addr  input  ADDR_W  source 0 register address (also driven to rf p0_addr)
id_p1_addr  input  ADDR_W  source 1 register address
id_re0  input  1  source 0 used
id_re1  input  1  source 1 used
id_dst_addr  input  ADDR_W  destination register
id_we  input  1  instruction writes a register
id_is_load  input  1  instruction is a load (result available after MEM)
rf_p0  input  DATA_W  rf read port 0 data
rf_p1  input  DATA_W  rf read port 1 data
ex_result  input  DATA_W  combinational ALU result of the instruction currently in EX
mem_result  input  DATA_W  result held in the EX/MEM register
mem_dst_addr  input  ADDR_W  EX/MEM destination
mem_we  input  1  EX/MEM writes a register (includes MEM valid)
stall  input  1  external pipeline hold (e.g. memory busy)
flush  input  1  squash the ID instruction (branch taken)
ex_valid  output  1  EX register holds a real instruction
ex_op0  output  DATA_W  resolved operand 0
ex_op1  output  DATA_W  resolved operand 1
ex_dst_addr  output  ADDR_W  registered destination
ex_we  output  1  registered write enable (0 when !ex_valid)
ex_is_load  output  1  registered load flag (0 when !ex_valid)
load_use_stall  output  1  combinational; front end must hold PC and IF/ID this cycle
stall_count  output  CNT_W  number of cycles load_use_stall was asserted and taken

Behaviour:
- Reset (async, rst=1): ex_valid=0, ex_op0=0, ex_op1=0, ex_dst_addr=0, ex_we=0, ex_is_load=0, stall_count=0. Reset mid-operation discards the EX contents immediately, without waiting for a clock edge.
- Match rule for source s (0/1): hit_ex_s = id_re_s & ex_valid & ex_we & (ex_dst_addr==id_ps_addr) & (id_ps_addr!=0). hit_mem_s uses mem_we/mem_dst_addr the same way. R0 never matches.
- load_use_stall = id_valid & ex_is_load & (hit_ex_0 | hit_ex_1). It is never asserted while stall=1; the external hold already covers it.
- Operand select, highest priority first:
  - hit_ex_s & !ex_is_load -> ex_result
  - hit_mem_s -> mem_result
  - otherwise rf_ps
  - A source with id_re_s=0 captures rf_ps unchanged (don't-care, but deterministic).
- Rising-edge update priority:
  1. flush: ex_valid/ex_we/ex_is_load <= 0; operands and dst are don't-care (hold). Flush wins over stall and load_use_stall.
  2. stall: all EX registers hold; stall_count holds.
  3. load_use_stall: insert a bubble (ex_valid=ex_we=ex_is_load=0); stall_count += 1, saturating at all-ones. On the next cycle the load has moved to MEM, so hit_mem supplies the data.
  4. Otherwise: capture ex_valid=id_valid; ex_we=id_we&id_valid; ex_is_load=id_is_load&id_valid; ex_dst_addr=id_dst_addr; ex_op0/ex_op1 = selected operands.
- Latency: 1 cycle from ID to EX outputs. A load-use hazard adds exactly 1 bubble cycle.
- Both sources hit the same EX load: one stall only. Source 0 hitting EX and source 1 hitting MEM: each forwarded independently.
- id_valid=0: capture a bubble; load_use_stall stays 0.

Test Plan:
- Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 immediately; release, then id_valid with rf_p0=16'h1234, rf_p1=16'h00FF, no hits -> next cycle ex_op0=1234, ex_op1=00FF, ex_valid=1.
- EX forward: EX holds ADD R3 (ex_we=1, ex_dst=3, ex_result=16'hBEEF); ID reads R3 on p0 with rf_p0=16'h0000 -> ex_op0=BEEF. Repeat with mem_dst=3, mem_result=16'h1111 also matching -> still BEEF (EX priority).
- R0 guard: ex_dst=0, ex_we=1, ID reads R0 -> ex_op0=rf_p0=0000, no forwarding, no stall.
- Load-use: EX holds LW R5; ID reads R5 on p1 -> load_use_stall=1 for exactly 1 cycle, bubble inserted, stall_count=1; next cycle mem_dst=5, mem_result=16'hCAFE -> ex_op1=CAFE, ex_valid=1.
- Stall/flush precedence: stall=1 for 3 cycles with new ID data -> EX outputs unchanged, stall_count unchanged; stall=1 and flush=1 together -> ex_valid=0 next cycle.
- Counter saturation: with CNT_W=4, force 17 load-use stalls -> stall_count stays at 4'hF.
